// File: rtl/tank_level_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tank_level_ctrl
// Purpose  : Tank pump / outlet-valve / alarm controller. N_LVL level sensors
//            form a thermometer code. The pump runs with hysteresis between
//            ON_LVL and OFF_LVL, with a minimum run time, a fill timeout and
//            a latched fault that the operator releases with ack.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous, active-high, clears all state
//            lvl    - level sensors, thermometer code (lvl[i]=1: at/above i)
//            ack    - operator acknowledge, releases FAULT
//            P      - pump on        (only in FILL)
//            E      - outlet valve   (level >= 1 and not in FAULT)
//            A      - alarm          (only in FAULT)
// Options  : TANK_SYNC_EN - when defined, lvl and ack pass through a 2-flop
//            synchroniser before use (every response 2 cycles later).
// Revision : 1.0 - initial release
// ============================================================================
module tank_level_ctrl #(
   parameter int N_LVL   = 4,
   parameter int ON_LVL  = 1,
   parameter int OFF_LVL = 3,
   parameter int MIN_ON  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_LVL-1:0] lvl,
   input  logic             ack,
   output logic             P,
   output logic             E,
   output logic             A
);

   localparam int c_LW = $clog2(N_LVL + 1);
   localparam int c_RW = $clog2(MIN_ON) + 1;
   localparam int c_TW = $clog2(TIMEOUT) + 1;

   localparam logic [c_LW-1:0] c_ON      = c_LW'(ON_LVL);
   localparam logic [c_LW-1:0] c_OFF     = c_LW'(OFF_LVL);
   localparam logic [c_LW-1:0] c_FULL    = c_LW'(N_LVL);
   localparam logic [c_RW-1:0] c_RUN_MAX = c_RW'(MIN_ON - 1);
   localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [c_RW-1:0]   r_run, w_run_nxt;
   logic [c_TW-1:0]   r_tmo, w_tmo_nxt;
   logic [1:0]        r_bad, w_bad_nxt;
   // Last valid level count. It is both the held level while the code is
   // invalid and the previous-cycle level used for the rise test.
   logic [c_LW-1:0]   r_L;

   logic [N_LVL-1:0]  w_lvl;
   logic              w_ack;
   logic              w_valid;
   logic [c_LW-1:0]   w_cnt;
   logic [c_LW-1:0]   w_L;
   logic              w_bad_trip;
   logic              w_rise;

   // ------------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------------
`ifdef TANK_SYNC_EN
   logic [N_LVL-1:0] r_lvl_s1, r_lvl_s2;
   logic             r_ack_s1, r_ack_s2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lvl_s1 <= '0;
         r_lvl_s2 <= '0;
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
      end else begin
         r_lvl_s1 <= lvl;
         r_lvl_s2 <= r_lvl_s1;
         r_ack_s1 <= ack;
         r_ack_s2 <= r_ack_s1;
      end
   end

   assign w_lvl = r_lvl_s2;
   assign w_ack = r_ack_s2;
`else
   assign w_lvl = lvl;
   assign w_ack = ack;
`endif

   // ------------------------------------------------------------------------
   // Thermometer decode: a 1 directly above a 0 anywhere marks the code bad.
   // ------------------------------------------------------------------------
   always_comb begin
      w_valid = 1'b1;
      w_cnt   = '0;
      for (int i = 0; i < N_LVL; i++) begin
         if (w_lvl[i]) w_cnt = w_cnt + c_LW'(1);
      end
      for (int i = 1; i < N_LVL; i++) begin
         if (w_lvl[i] && !w_lvl[i-1]) w_valid = 1'b0;
      end
   end

   assign w_L        = w_valid ? w_cnt : r_L;
   assign w_bad_nxt  = w_valid ? 2'd0 : ((r_bad == 2'd3) ? 2'd3 : r_bad + 2'd1);
   assign w_bad_trip = w_bad_nxt[1];
   assign w_rise     = (w_L > r_L);

   // ------------------------------------------------------------------------
   // Next state, counters and Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = '0;
      w_tmo_nxt   = '0;
      P           = (r_state == S_FILL);
      A           = (r_state == S_FAULT);
      E           = (r_L != '0) && (r_state != S_FAULT);

      case (r_state)
         S_IDLE: begin
            if (w_bad_trip)
               w_state_nxt = S_FAULT;
            else if ((w_L <= c_ON) && (w_L < c_FULL))
               w_state_nxt = S_FILL;
         end
         S_FILL: begin
            if (w_bad_trip)
               w_state_nxt = S_FAULT;
            else if (w_L == c_FULL)
               w_state_nxt = S_IDLE;
            else if ((r_tmo == c_TMO_MAX) && !w_rise)
               w_state_nxt = S_FAULT;
            else if ((w_L >= c_OFF) && (r_run >= c_RUN_MAX))
               w_state_nxt = S_IDLE;
            else begin
               w_run_nxt = (r_run >= c_RUN_MAX) ? r_run : r_run + c_RW'(1);
               // The timeout branch above guarantees r_tmo < c_TMO_MAX here
               // whenever the level did not rise, so the increment cannot wrap.
               w_tmo_nxt = w_rise ? '0 : r_tmo + c_TW'(1);
            end
         end
         S_FAULT: begin
            if (w_ack && w_valid)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_FAULT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_run   <= '0;
         r_tmo   <= '0;
         r_bad   <= 2'd0;
         r_L     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_tmo   <= w_tmo_nxt;
         r_bad   <= w_bad_nxt;
         r_L     <= w_L;
      end
   end

endmodule
`default_nettype wire
